dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 159 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-allocate data cache controller.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int N_LINES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Stall,
  output logic        Hit,
  input  logic        memory_ready,
  input  logic [31:0] MemRdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HitCount,
  output logic [15:0] MissCount
`endif
);

  localparam int IW = $clog2(N_LINES);
  localparam int TW = 30 - IW;

  typedef enum logic [1:0] {
    IDLE,
    MISS_WAIT,
    FILL
  } state_e;

  state_e              state_q, state_d;
  logic [N_LINES-1:0]  valid_q, valid_d;
  logic [IW-1:0]       miss_idx_q, miss_idx_d;
  logic [TW-1:0]       miss_tag_q, miss_tag_d;

  logic [TW-1:0]       tag_arr  [N_LINES];
  logic [31:0]         data_arr [N_LINES];

  logic [IW-1:0]       idx;
  logic [TW-1:0]       tag;
  logic                tag_match;
  logic                addr_unused;

  logic                wr_en;
  logic [IW-1:0]       wr_idx;
  logic [TW-1:0]       wr_tag;
  logic [31:0]         wr_data;
  logic                stall;
  logic                hit;
  logic [31:0]         rdata;

  assign idx         = Addr[IW+1:2];
  assign tag         = Addr[31:IW+2];
  assign addr_unused = ^Addr[1:0];
  assign tag_match   = valid_q[idx] && (tag_arr[idx] == tag);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    wr_en      = 1'b0;
    wr_idx     = idx;
    wr_tag     = tag;
    wr_data    = WData;
    stall      = 1'b0;
    hit        = 1'b1;
    rdata      = data_arr[idx];
    unique case (state_q)
      IDLE: begin
        // A simultaneous read and write is handled as a plain store.
        if (MemWrite) begin
          wr_en = tag_match;
        end else if (MemRead && !tag_match) begin
          stall      = 1'b1;
          hit        = 1'b0;
          miss_idx_d = idx;
          miss_tag_d = tag;
          state_d    = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        stall = 1'b1;
        hit   = 1'b0;
        if (memory_ready) begin
          wr_en               = 1'b1;
          wr_idx              = miss_idx_q;
          wr_tag              = miss_tag_q;
          wr_data             = MemRdata;
          valid_d[miss_idx_q] = 1'b1;
          state_d             = FILL;
        end
      end
      FILL: begin
        rdata   = data_arr[miss_idx_q];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  // Tag and data storage carry no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_arr[wr_idx]  <= wr_tag;
      data_arr[wr_idx] <= wr_data;
    end
  end

  assign Stall = RESET & stall;
  assign Hit   = ~RESET | hit;
  assign RData = RESET ? rdata : 32'h0;

`ifdef DCACHE_STATS_EN
  logic        hit_inc, miss_inc;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  assign hit_inc  = (state_q == IDLE) && MemRead && !MemWrite && tag_match;
  assign miss_inc = (state_q == IDLE) && (state_d == MISS_WAIT);

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
    if (miss_inc && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: vector table plus corner sequences.
// Expected load data is queued at issue and popped when the load completes.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        memory_ready = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WData = '0;
  logic [31:0] MemRdata = '0;
  logic [31:0] RData;
  logic        Stall;
  logic        Hit;
`ifdef DCACHE_STATS_EN
  logic [15:0] HitCount;
  logic [15:0] MissCount;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] sb_q [$];

  always #5 CLK = ~CLK;

  dcache_ctrl #(.N_LINES(16)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .Addr(Addr),
    .WData(WData),
    .RData(RData),
    .Stall(Stall),
    .Hit(Hit),
    .memory_ready(memory_ready),
    .MemRdata(MemRdata)
`ifdef DCACHE_STATS_EN
    ,
    .HitCount(HitCount),
    .MissCount(MissCount)
`endif
  );

  typedef enum int {OP_IDLE, OP_LD, OP_ST, OP_BOTH} op_e;

  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    bit          miss;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef DCACHE_STATS_EN
    chk("hit_count", {16'h0, HitCount}, 32'(exp_hits));
    chk("miss_count", {16'h0, MissCount}, 32'(exp_misses));
`endif
  endtask

  task automatic do_load(input logic [31:0] a, input int delay,
                         input bit miss, input logic [31:0] d,
                         input logic [31:0] alt);
    int cyc;
    logic [31:0] want;
    @(negedge CLK);
    MemRead = 1'b1;
    MemWrite = 1'b0;
    Addr = a;
    memory_ready = 1'b0;
    sb_q.push_back(d);
    #1;
    chk("issue_stall", {31'h0, Stall}, {31'h0, miss});
    chk("issue_hit", {31'h0, Hit}, {31'h0, !miss});
    if (miss) exp_misses++;
    else exp_hits++;
    cyc = 1;
    while (Stall && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 2 && alt != 32'h0) Addr = alt;
      memory_ready = (cyc == delay + 1);
      MemRdata = memory_ready ? mem[a] : 32'hBAD0_BAD0;
      #1;
    end
    memory_ready = 1'b0;
    want = sb_q.pop_front();
    chk("load_data", RData, want);
    chk("load_done_hit", {31'h0, Hit}, 32'h1);
    chk("load_latency", 32'(cyc), miss ? 32'(delay + 2) : 32'h1);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] wd,
                          input bit rd);
    @(negedge CLK);
    MemRead = rd;
    MemWrite = 1'b1;
    Addr = a;
    WData = wd;
    memory_ready = 1'b0;
    mem[a] = wd;
    #1;
    chk("store_stall", {31'h0, Stall}, 32'h0);
  endtask

  task automatic do_idle(input logic [31:0] a, input bit mr);
    @(negedge CLK);
    MemRead = 1'b0;
    MemWrite = 1'b0;
    Addr = a;
    memory_ready = mr;
    MemRdata = 32'h0000_0BAD;
    #1;
    chk("idle_stall", {31'h0, Stall}, 32'h0);
    chk("idle_hit", {31'h0, Hit}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mem[32'h810] = 32'h5;
    mem[32'h820] = 32'h22;
    mem[32'h850] = 32'h55;
    mem[32'h004] = 32'h1234;
    mem[32'h03C] = 32'h3C3C;
    mem[32'h900] = 32'hC0DE;
    mem[32'hA04] = 32'hA0A0;
    mem[32'h040] = 32'h4040;

    tbl[0]  = '{OP_IDLE, 32'h810, 32'h0,  0, 1'b0, 32'h0};
    tbl[1]  = '{OP_LD,   32'h810, 32'h0,  5, 1'b1, 32'h5};
    tbl[2]  = '{OP_LD,   32'h810, 32'h0,  0, 1'b0, 32'h5};
    tbl[3]  = '{OP_ST,   32'h810, 32'hA,  0, 1'b0, 32'h0};
    tbl[4]  = '{OP_LD,   32'h810, 32'h0,  0, 1'b0, 32'hA};
    tbl[5]  = '{OP_ST,   32'h820, 32'h77, 0, 1'b0, 32'h0};
    tbl[6]  = '{OP_LD,   32'h820, 32'h0,  3, 1'b1, 32'h77};
    tbl[7]  = '{OP_LD,   32'h810, 32'h0,  0, 1'b0, 32'hA};
    tbl[8]  = '{OP_LD,   32'h850, 32'h0,  2, 1'b1, 32'h55};
    tbl[9]  = '{OP_LD,   32'h810, 32'h0,  4, 1'b1, 32'hA};
    tbl[10] = '{OP_LD,   32'h850, 32'h0,  1, 1'b1, 32'h55};
    tbl[11] = '{OP_BOTH, 32'h850, 32'h99, 0, 1'b0, 32'h0};
    tbl[12] = '{OP_LD,   32'h850, 32'h0,  0, 1'b0, 32'h99};
    tbl[13] = '{OP_BOTH, 32'h810, 32'hBB, 0, 1'b0, 32'h0};
    tbl[14] = '{OP_LD,   32'h810, 32'h0,  2, 1'b1, 32'hBB};
    tbl[15] = '{OP_LD,   32'h004, 32'h0,  5, 1'b1, 32'h1234};
    tbl[16] = '{OP_LD,   32'h03C, 32'h0,  1, 1'b1, 32'h3C3C};
    tbl[17] = '{OP_LD,   32'h004, 32'h0,  0, 1'b0, 32'h1234};
    tbl[18] = '{OP_LD,   32'h03C, 32'h0,  0, 1'b0, 32'h3C3C};
    tbl[19] = '{OP_LD,   32'h810, 32'h0,  0, 1'b0, 32'hBB};

    MemRead = 1'b1;
    Addr = 32'h810;
    #2;
    chk("rst_stall", {31'h0, Stall}, 32'h0);
    chk("rst_hit", {31'h0, Hit}, 32'h1);
    chk("rst_rdata", RData, 32'h0);
    chk_stats();
    @(negedge CLK);
    MemRead = 1'b0;
    RESET = 1'b1;

    for (int i = 0; i < 20; i++) begin
      case (tbl[i].op)
        OP_IDLE: do_idle(tbl[i].addr, 1'b0);
        OP_LD:   do_load(tbl[i].addr, tbl[i].delay, tbl[i].miss,
                         tbl[i].data, 32'h0);
        OP_ST:   do_store(tbl[i].addr, tbl[i].wdata, 1'b0);
        default: do_store(tbl[i].addr, tbl[i].wdata, 1'b1);
      endcase
    end
    chk_stats();

    do_idle(32'h810, 1'b1);
    do_load(32'h810, 0, 1'b0, 32'hBB, 32'h0);

    do_load(32'h900, 3, 1'b1, 32'hC0DE, 32'hA04);
    do_load(32'h900, 0, 1'b0, 32'hC0DE, 32'h0);
    do_load(32'h004, 0, 1'b0, 32'h1234, 32'h0);
    do_load(32'hA04, 2, 1'b1, 32'hA0A0, 32'h0);

    @(negedge CLK);
    MemRead = 1'b1;
    MemWrite = 1'b0;
    Addr = 32'h040;
    #1;
    chk("rstmiss_issue", {31'h0, Stall}, 32'h1);
    @(negedge CLK);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    #1;
    chk("rstmiss_stall", {31'h0, Stall}, 32'h0);
    chk("rstmiss_hit", {31'h0, Hit}, 32'h1);
    chk("rstmiss_rdata", RData, 32'h0);
    chk_stats();
    @(negedge CLK);
    RESET = 1'b1;
    MemRead = 1'b0;
    memory_ready = 1'b1;
    MemRdata = 32'hDEAD;
    do_load(32'h810, 5, 1'b1, 32'hBB, 32'h0);
    do_load(32'h040, 1, 1'b1, 32'h4040, 32'h0);
    do_load(32'h040, 0, 1'b0, 32'h4040, 32'h0);
    chk_stats();

    @(negedge CLK);
    MemRead = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
